// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/forwarding controller.
// Forward-select codes, debug FSM states and stage indices.
package pipe_ctrl_pkg;

  localparam logic [1:0] FWD_RF      = 2'd0;
  localparam logic [1:0] FWD_EXE     = 2'd1;
  localparam logic [1:0] FWD_MEM_ALU = 2'd2;
  localparam logic [1:0] FWD_MEM_LD  = 2'd3;

  typedef enum logic [1:0] {
    DBG_RUN  = 2'd0,
    DBG_HALT = 2'd1,
    DBG_STEP = 2'd2
  } dbg_state_t;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EXE = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

endpackage

// File: rtl/pipe_hazard_ctrl_dbg.sv
// Debug hold / single-step FSM with a rising-edge detector on dbg_step.
// STEP always lasts one cycle so the pipeline advances exactly one clock.
module dbg_step_fsm
  import pipe_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       dbg_en,
  input  logic       dbg_step,
  output dbg_state_t dbg_state
);

  dbg_state_t state_q;
  dbg_state_t state_d;
  logic       step_prev;
  logic       step_edge;

  assign step_edge = dbg_step & ~step_prev;
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DBG_RUN;
      step_prev <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_prev <= dbg_step;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DBG_RUN: begin
        if (dbg_en) state_d = DBG_HALT;
      end
      DBG_HALT: begin
        if (!dbg_en)        state_d = DBG_RUN;
        else if (step_edge) state_d = DBG_STEP;
      end
      DBG_STEP: begin
        state_d = dbg_en ? DBG_HALT : DBG_RUN;
      end
      default: state_d = DBG_RUN;
    endcase
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and stage-control unit beside the ID stage.
// Adds debug single-step and saturating stall/flush counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int NUM_SRC = 2,
  parameter int NUM_STG = 5,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      dbg_en,
  input  logic                      dbg_step,
  input  logic [NUM_SRC-1:0]        src_used,
  input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
  input  logic                      exe_wen,
  input  logic                      exe_is_load,
  input  logic [ADDR_W-1:0]         exe_waddr,
  input  logic                      mem_wen,
  input  logic                      mem_is_load,
  input  logic                      mem_is_store,
  input  logic [ADDR_W-1:0]         mem_waddr,
  input  logic [ADDR_W-1:0]         mem_rt_addr,
  input  logic                      wb_wen,
  input  logic [ADDR_W-1:0]         wb_waddr,
  input  logic                      exe_busy,
  input  logic                      branch_taken,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic                      fwd_m,
  output logic [NUM_STG-1:0]        stg_en,
  output logic [NUM_STG-1:0]        stg_rst,
  output logic [1:0]                dbg_state,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  dbg_state_t         dbg_st;
  logic [NUM_SRC-1:0] lu_src;
  logic               load_use;
  logic               halt;
  logic               flush_apply;
  logic               stall_ev;

  dbg_step_fsm u_dbg (
    .clk      (clk),
    .rst      (rst),
    .dbg_en   (dbg_en),
    .dbg_step (dbg_step),
    .dbg_state(dbg_st)
  );

  assign dbg_state = dbg_st;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [ADDR_W-1:0] addr;
    logic              rd;
    logic              exe_hit;
    logic              mem_hit;

    assign addr    = src_addr[i*ADDR_W +: ADDR_W];
    assign rd      = src_used[i] && (addr != '0);
    assign exe_hit = rd && exe_wen && (exe_waddr == addr);
    assign mem_hit = rd && mem_wen && (mem_waddr == addr);

    assign lu_src[i] = exe_hit && exe_is_load;

    // A load in EXE has no data yet: the stall covers it, not MEM.
    assign fwd_sel[2*i +: 2] =
      exe_hit ? (exe_is_load ? FWD_RF : FWD_EXE) :
      mem_hit ? (mem_is_load ? FWD_MEM_LD : FWD_MEM_ALU) :
      FWD_RF;
  end

  assign load_use = |lu_src;
  assign halt     = (dbg_st == DBG_HALT);

  assign fwd_m = mem_is_store && (mem_rt_addr != '0) &&
                 wb_wen && (wb_waddr == mem_rt_addr);

  always_comb begin
    stg_en      = '1;
    stg_rst     = '0;
    flush_apply = 1'b0;
    if (rst) begin
      stg_rst = '1;
    end else if (halt) begin
      stg_en = '0;
    end else if (exe_busy) begin
      stg_en[STG_EXE:STG_IF] = '0;
      stg_rst[STG_MEM]       = 1'b1;
    end else if (load_use) begin
      stg_en[STG_ID:STG_IF] = '0;
      stg_rst[STG_EXE]      = 1'b1;
    end else if (branch_taken) begin
      stg_rst[STG_ID] = 1'b1;
      flush_apply     = 1'b1;
    end
  end

  assign stall_ev = (exe_busy || load_use) && !halt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_ev && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + CNT_ONE;
      if (flush_apply && flush_cnt != CNT_MAX)
        flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl.
// Expected values queued at drive time, popped at the negedge sample.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic        dbg_en, dbg_step;
  logic [1:0]  src_used;
  logic [9:0]  src_addr;
  logic        exe_wen, exe_is_load;
  logic [4:0]  exe_waddr;
  logic        mem_wen, mem_is_load, mem_is_store;
  logic [4:0]  mem_waddr, mem_rt_addr;
  logic        wb_wen;
  logic [4:0]  wb_waddr;
  logic        exe_busy, branch_taken;

  logic [3:0]  fwd_sel;
  logic        fwd_m;
  logic [4:0]  stg_en, stg_rst;
  logic [1:0]  dbg_state;
  logic [15:0] stall_cnt, flush_cnt;

  logic [3:0]  s_fwd;
  logic        s_fm;
  logic [4:0]  s_en, s_rs;
  logic [1:0]  s_st;
  logic [1:0]  s_stall, s_flush;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] fwd;
    logic       fm;
    logic [4:0] en;
    logic [4:0] rs;
    logic [1:0] st;
  } exp_t;

  exp_t sbq[$];

  pipe_hazard_ctrl u_dut (
    .clk(clk), .rst(rst), .dbg_en(dbg_en), .dbg_step(dbg_step),
    .src_used(src_used), .src_addr(src_addr),
    .exe_wen(exe_wen), .exe_is_load(exe_is_load),
    .exe_waddr(exe_waddr),
    .mem_wen(mem_wen), .mem_is_load(mem_is_load),
    .mem_is_store(mem_is_store),
    .mem_waddr(mem_waddr), .mem_rt_addr(mem_rt_addr),
    .wb_wen(wb_wen), .wb_waddr(wb_waddr),
    .exe_busy(exe_busy), .branch_taken(branch_taken),
    .fwd_sel(fwd_sel), .fwd_m(fwd_m),
    .stg_en(stg_en), .stg_rst(stg_rst),
    .dbg_state(dbg_state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .dbg_en(dbg_en), .dbg_step(dbg_step),
    .src_used(src_used), .src_addr(src_addr),
    .exe_wen(exe_wen), .exe_is_load(exe_is_load),
    .exe_waddr(exe_waddr),
    .mem_wen(mem_wen), .mem_is_load(mem_is_load),
    .mem_is_store(mem_is_store),
    .mem_waddr(mem_waddr), .mem_rt_addr(mem_rt_addr),
    .wb_wen(wb_wen), .wb_waddr(wb_waddr),
    .exe_busy(exe_busy), .branch_taken(branch_taken),
    .fwd_sel(s_fwd), .fwd_m(s_fm),
    .stg_en(s_en), .stg_rst(s_rs),
    .dbg_state(s_st),
    .stall_cnt(s_stall), .flush_cnt(s_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dbg_en = 0; dbg_step = 0;
    src_used = 0; src_addr = 0;
    exe_wen = 0; exe_is_load = 0; exe_waddr = 0;
    mem_wen = 0; mem_is_load = 0; mem_is_store = 0;
    mem_waddr = 0; mem_rt_addr = 0;
    wb_wen = 0; wb_waddr = 0;
    exe_busy = 0; branch_taken = 0;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1;
    idle();
    tick();
    exe_wen = 1; exe_waddr = 5'd3;
    src_used = 2'b01; src_addr = {5'd0, 5'd3};
    sbq.push_back('{4'b0001, 1'b0, 5'h1f, 5'h1f, DBG_RUN});
    @(negedge clk);
    e = sbq.pop_front();
    checks++;
    if (stg_rst !== e.rs) begin
      errors++;
      $display("FAIL rst_stg_rst: got %b want %b", stg_rst, e.rs);
    end
    checks++;
    if (stg_en !== e.en) begin
      errors++;
      $display("FAIL rst_stg_en: got %b want %b", stg_en, e.en);
    end
    checks++;
    if (fwd_sel !== e.fwd) begin
      errors++;
      $display("FAIL rst_fwd: got %b want %b", fwd_sel, e.fwd);
    end
    tick();
    rst = 0;
    idle();
    sbq.push_back('{4'b0000, 1'b0, 5'h1f, 5'h00, DBG_RUN});
    @(negedge clk);
    e = sbq.pop_front();
    checks++;
    if (dbg_state !== e.st || stall_cnt !== 16'd0 ||
        flush_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_regs: got st=%0d stall=%0d flush=%0d want %0d/0/0",
               dbg_state, stall_cnt, flush_cnt, e.st);
    end
    checks++;
    if (stg_en !== e.en || stg_rst !== e.rs) begin
      errors++;
      $display("FAIL reset_idle_stg: got en=%b rst=%b want %b/%b",
               stg_en, stg_rst, e.en, e.rs);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    idle();
    exe_wen = 1; exe_waddr = 5'd3;
    src_used = 2'b11; src_addr = {5'd3, 5'd3};
    sbq.push_back('{4'b0101, 1'b0, 5'h1f, 5'h00, DBG_RUN});
    @(negedge clk);
    e = sbq.pop_front();
    checks++;
    if (fwd_sel !== e.fwd || stg_en !== e.en) begin
      errors++;
      $display("FAIL b2b_exe: got fwd=%b en=%b want %b/%b",
               fwd_sel, stg_en, e.fwd, e.en);
    end
    tick();
    exe_wen = 0; mem_wen = 1; mem_waddr = 5'd3;
    sbq.push_back('{4'b1010, 1'b0, 5'h1f, 5'h00, DBG_RUN});
    @(negedge clk);
    e = sbq.pop_front();
    checks++;
    if (fwd_sel !== e.fwd) begin
      errors++;
      $display("FAIL b2b_mem: got %b want %b", fwd_sel, e.fwd);
    end
    tick();
    exe_wen = 1; exe_waddr = 5'd3; mem_waddr = 5'd4;
    src_addr = {5'd4, 5'd3};
    sbq.push_back('{4'b1001, 1'b0, 5'h1f, 5'h00, DBG_RUN});
    @(negedge clk);
    e = sbq.pop_front();
    checks++;
    if (fwd_sel !== e.fwd) begin
      errors++;
      $display("FAIL b2b_mixed: got %b want %b", fwd_sel, e.fwd);
    end
    tick();
  endtask

  task automatic test_load_use();
    exp_t e;
    logic [15:0] s0, f0;
    s0 = stall_cnt; f0 = flush_cnt;
    idle();
    exe_wen = 1; exe_is_load = 1; exe_waddr = 5'd5;
    src_used = 2'b10; src_addr = {5'd5, 5'd9};
    branch_taken = 1;
    sbq.push_back('{4'b0000, 1'b0, 5'b11100, 5'b00100, DBG_RUN});
    @(negedge clk);
    e = sbq.pop_front();
    checks++;
    if (stg_en !== e.en || stg_rst !== e.rs) begin
      errors++;
      $display("FAIL load_use_stall: got en=%b rst=%b want %b/%b",
               stg_en, stg_rst, e.en, e.rs);
    end
    tick();
    exe_wen = 0; exe_is_load = 0; branch_taken = 0;
    mem_wen = 1; mem_is_load = 1; mem_waddr = 5'd5;
    sbq.push_back('{4'b1100, 1'b0, 5'h1f, 5'h00, DBG_RUN});
    @(negedge clk);
    e = sbq.pop_front();
    checks++;
    if (fwd_sel !== e.fwd || stg_en !== e.en || stg_rst !== e.rs) begin
      errors++;
      $display("FAIL load_use_next: got fwd=%b en=%b rst=%b want %b/%b/%b",
               fwd_sel, stg_en, stg_rst, e.fwd, e.en, e.rs);
    end
    checks++;
    if (stall_cnt !== s0 + 16'd1 || flush_cnt !== f0) begin
      errors++;
      $display("FAIL load_use_cnt: got stall=%0d flush=%0d want %0d/%0d",
               stall_cnt, flush_cnt, s0 + 16'd1, f0);
    end
    tick();
  endtask

  task automatic test_r0_store();
    exp_t e;
    logic [4:0] rt_t[3] = '{5'd7, 5'd7, 5'd0};
    logic [4:0] wa_t[3] = '{5'd7, 5'd6, 5'd0};
    logic       fm_t[3] = '{1'b1, 1'b0, 1'b0};
    idle();
    exe_wen = 1; exe_is_load = 1; exe_waddr = 5'd0;
    mem_wen = 1; mem_waddr = 5'd0;
    src_used = 2'b11; src_addr = 10'd0;
    sbq.push_back('{4'b0000, 1'b0, 5'h1f, 5'h00, DBG_RUN});
    @(negedge clk);
    e = sbq.pop_front();
    checks++;
    if (fwd_sel !== e.fwd || stg_en !== e.en || stg_rst !== e.rs) begin
      errors++;
      $display("FAIL r0_guard: got fwd=%b en=%b rst=%b want %b/%b/%b",
               fwd_sel, stg_en, stg_rst, e.fwd, e.en, e.rs);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      idle();
      mem_is_store = 1; mem_rt_addr = rt_t[i];
      wb_wen = 1; wb_waddr = wa_t[i];
      sbq.push_back('{4'b0000, fm_t[i], 5'h1f, 5'h00, DBG_RUN});
      @(negedge clk);
      e = sbq.pop_front();
      checks++;
      if (fwd_m !== e.fm) begin
        errors++;
        $display("FAIL store_fwd_m[%0d]: got %b want %b", i, fwd_m, e.fm);
      end
    end
    tick();
  endtask

  task automatic test_branch();
    exp_t e;
    logic [15:0] s0, f0;
    s0 = stall_cnt; f0 = flush_cnt;
    idle();
    branch_taken = 1;
    sbq.push_back('{4'b0000, 1'b0, 5'h1f, 5'b00010, DBG_RUN});
    @(negedge clk);
    e = sbq.pop_front();
    checks++;
    if (stg_en !== e.en || stg_rst !== e.rs) begin
      errors++;
      $display("FAIL branch_flush: got en=%b rst=%b want %b/%b",
               stg_en, stg_rst, e.en, e.rs);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (flush_cnt !== f0 + 16'd1 || stall_cnt !== s0) begin
      errors++;
      $display("FAIL branch_cnt: got flush=%0d stall=%0d want %0d/%0d",
               flush_cnt, stall_cnt, f0 + 16'd1, s0);
    end
    tick();
  endtask

  task automatic test_busy_branch();
    exp_t e;
    logic [15:0] s0, f0;
    s0 = stall_cnt; f0 = flush_cnt;
    for (int i = 0; i < 4; i++) begin
      idle();
      exe_busy = 1; branch_taken = 1;
      if (i == 2) begin
        exe_wen = 1; exe_is_load = 1; exe_waddr = 5'd8;
        src_used = 2'b01; src_addr = {5'd0, 5'd8};
      end
      sbq.push_back('{4'b0000, 1'b0, 5'b11000, 5'b01000, DBG_RUN});
      @(negedge clk);
      e = sbq.pop_front();
      checks++;
      if (stg_en !== e.en || stg_rst !== e.rs) begin
        errors++;
        $display("FAIL busy[%0d]: got en=%b rst=%b want %b/%b",
                 i, stg_en, stg_rst, e.en, e.rs);
      end
      tick();
    end
    idle();
    @(negedge clk);
    checks++;
    if (stall_cnt !== s0 + 16'd4 || flush_cnt !== f0) begin
      errors++;
      $display("FAIL busy_cnt: got stall=%0d flush=%0d want %0d/%0d",
               stall_cnt, flush_cnt, s0 + 16'd4, f0);
    end
    tick();
  endtask

  task automatic test_debug();
    exp_t e;
    logic [15:0] s0, f0;
    logic [17:0] pat;
    int          steps;
    pat = 18'h0FFC9;
    steps = 0;
    idle();
    dbg_en = 1;
    sbq.push_back('{4'b0000, 1'b0, 5'h1f, 5'h00, DBG_RUN});
    @(negedge clk);
    e = sbq.pop_front();
    checks++;
    if (dbg_state !== e.st) begin
      errors++;
      $display("FAIL dbg_run_pre: got %0d want %0d", dbg_state, e.st);
    end
    tick();
    s0 = stall_cnt; f0 = flush_cnt;
    exe_busy = 1; branch_taken = 1;
    sbq.push_back('{4'b0000, 1'b0, 5'h00, 5'h00, DBG_HALT});
    @(negedge clk);
    e = sbq.pop_front();
    checks++;
    if (dbg_state !== e.st || stg_en !== e.en || stg_rst !== e.rs) begin
      errors++;
      $display("FAIL dbg_halt: got st=%0d en=%b rst=%b want %0d/%b/%b",
               dbg_state, stg_en, stg_rst, e.st, e.en, e.rs);
    end
    tick();
    exe_busy = 0; branch_taken = 0;
    for (int i = 0; i < 18; i++) begin
      dbg_step = pat[i];
      if (i == 1 || i == 4 || i == 7)
        sbq.push_back('{4'b0000, 1'b0, 5'h1f, 5'h00, DBG_STEP});
      else
        sbq.push_back('{4'b0000, 1'b0, 5'h00, 5'h00, DBG_HALT});
      @(negedge clk);
      e = sbq.pop_front();
      if (dbg_state === DBG_STEP) steps++;
      checks++;
      if (dbg_state !== e.st || stg_en !== e.en) begin
        errors++;
        $display("FAIL dbg_seq[%0d]: got st=%0d en=%b want %0d/%b",
                 i, dbg_state, stg_en, e.st, e.en);
      end
      tick();
    end
    checks++;
    if (steps != 3) begin
      errors++;
      $display("FAIL dbg_step_count: got %0d want 3", steps);
    end
    checks++;
    if (stall_cnt !== s0 || flush_cnt !== f0) begin
      errors++;
      $display("FAIL dbg_halt_cnt: got stall=%0d flush=%0d want %0d/%0d",
               stall_cnt, flush_cnt, s0, f0);
    end
    dbg_step = 0; dbg_en = 0;
    tick();
    sbq.push_back('{4'b0000, 1'b0, 5'h1f, 5'h00, DBG_RUN});
    @(negedge clk);
    e = sbq.pop_front();
    checks++;
    if (dbg_state !== e.st || stg_en !== e.en) begin
      errors++;
      $display("FAIL dbg_resume: got st=%0d en=%b want %0d/%b",
               dbg_state, stg_en, e.st, e.en);
    end
    tick();
  endtask

  task automatic test_saturation();
    exp_t e;
    idle();
    rst = 1;
    tick();
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      exe_busy = 1;
      tick();
    end
    dbg_en = 1;
    @(negedge clk);
    checks++;
    if (s_stall !== 2'd3 || stall_cnt !== 16'd6) begin
      errors++;
      $display("FAIL sat_stall: got sat=%0d wide=%0d want 3/6",
               s_stall, stall_cnt);
    end
    tick();
    rst = 1;
    sbq.push_back('{4'b0000, 1'b0, 5'h1f, 5'h1f, DBG_HALT});
    @(negedge clk);
    e = sbq.pop_front();
    checks++;
    if (dbg_state !== e.st || stg_en !== e.en || stg_rst !== e.rs) begin
      errors++;
      $display("FAIL rst_in_halt: got st=%0d en=%b rst=%b want %0d/%b/%b",
               dbg_state, stg_en, stg_rst, e.st, e.en, e.rs);
    end
    tick();
    rst = 0;
    idle();
    sbq.push_back('{4'b0000, 1'b0, 5'h1f, 5'h00, DBG_RUN});
    @(negedge clk);
    e = sbq.pop_front();
    checks++;
    if (dbg_state !== e.st || s_st !== e.st || stall_cnt !== 16'd0 ||
        s_stall !== 2'd0 || flush_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rst_mid_stall: got st=%0d/%0d stall=%0d/%0d flush=%0d want %0d 0 0",
               dbg_state, s_st, stall_cnt, s_stall, flush_cnt, e.st);
    end
    tick();
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_back_to_back();
    test_load_use();
    test_r0_store();
    test_branch();
    test_busy_branch();
    test_debug();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
